// File: rtl/id_hazard_scheduler_pkg.sv
// Shared definitions for the ID-stage hazard scheduler.
//  - forward-select encodings (SelA/SelB values)
//  - scheduler FSM state encodings (State_Dbg values)
//  - destination descriptor used for the EXE/MEM/WB write ports
package id_hazard_scheduler_pkg;

  localparam logic [1:0] FWD_SEL_REG = 2'd0;
  localparam logic [1:0] FWD_SEL_ALU = 2'd1;
  localparam logic [1:0] FWD_SEL_MEM = 2'd2;
  localparam logic [1:0] FWD_SEL_WB  = 2'd3;

  // Operand lanes: 0 = rs (A), 1 = rt (B)
  localparam int NUM_OPS = 2;

  typedef enum logic [2:0] {
    HS_IDLE        = 3'd0,
    HS_STALL       = 3'd1,
    HS_SYS_DRAIN   = 3'd2,
    HS_SYS_ISSUE   = 3'd3,
    HS_SYS_RECOVER = 3'd4
  } hs_state_e;

  typedef struct packed {
    logic [4:0] dst;
    logic       wen;
  } dest_t;

endpackage

// File: rtl/id_hazard_scheduler_fwd_select_unit.sv
// fwd_select_unit: priority forwarding select for one ID operand.
//  src/uses       : register read by ID and whether it is actually read
//  exe/mem/wb     : destination descriptors of the downstream stages
//  exe_load       : EXE instruction is a load
//  sel            : EXE(1) > MEM(2) > WB(3) > regfile(0)
//  exe_load_hit   : operand depends on the load currently in EXE
module fwd_select_unit
  import id_hazard_scheduler_pkg::*;
(
  input  logic [4:0] src,
  input  logic       uses,
  input  dest_t      exe,
  input  dest_t      mem,
  input  dest_t      wb,
  input  logic       exe_load,
  output logic [1:0] sel,
  output logic       exe_load_hit
);

  logic live, exe_hit, mem_hit, wb_hit;

  // $0 is hardwired zero, so it never needs forwarding
  assign live    = uses && (src != 5'd0);
  assign exe_hit = live && exe.wen && (exe.dst == src);
  assign mem_hit = live && mem.wen && (mem.dst == src);
  assign wb_hit  = live && wb.wen  && (wb.dst  == src);

  always_comb begin
    sel = FWD_SEL_REG;
    if (exe_hit)      sel = FWD_SEL_ALU;
    else if (mem_hit) sel = FWD_SEL_MEM;
    else if (wb_hit)  sel = FWD_SEL_WB;
  end

  // Selection still reports ALU for a load; the stall covers that case
  assign exe_load_hit = exe_hit && exe_load;

endmodule

// File: rtl/id_hazard_scheduler.sv
// id_hazard_scheduler: ID-stage pipeline-control scheduler.
//  Inputs : ID operand info (ID_RegA/B, ID_UsesA/B, ID_BranchJR, ID_Syscall),
//           EXE/MEM/WB destination info, CLK, RESET (sync, active low).
//  Outputs: SelA/SelB forward selects (combinational), Stall, SYS pulse,
//           WANT_FREEZE fetch freeze, State_Dbg current FSM state.
module id_hazard_scheduler
  import id_hazard_scheduler_pkg::*;
#(
  parameter int SYS_DRAIN_CYCLES = 3,
  parameter int BR_LOAD_STALLS   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] ID_RegA,
  input  logic [4:0] ID_RegB,
  input  logic       ID_UsesA,
  input  logic       ID_UsesB,
  input  logic       ID_BranchJR,
  input  logic       ID_Syscall,
  input  logic [4:0] EXE_WriteReg,
  input  logic       EXE_RegWrite,
  input  logic       EXE_MemRead,
  input  logic [4:0] MEM_WriteReg,
  input  logic       MEM_RegWrite,
  input  logic [4:0] WB_WriteReg,
  input  logic       WB_RegWrite,
  output logic [1:0] SelA,
  output logic [1:0] SelB,
  output logic       Stall,
  output logic       SYS,
  output logic       WANT_FREEZE,
  output logic [2:0] State_Dbg
);

  if (SYS_DRAIN_CYCLES < 1 || SYS_DRAIN_CYCLES > 7) begin : g_bad_sys
    $error("id_hazard_scheduler: SYS_DRAIN_CYCLES=%0d outside 1..7", SYS_DRAIN_CYCLES);
  end
  if (BR_LOAD_STALLS < 1 || BR_LOAD_STALLS > 7) begin : g_bad_br
    $error("id_hazard_scheduler: BR_LOAD_STALLS=%0d outside 1..7", BR_LOAD_STALLS);
  end

  localparam logic [2:0] SYS_CNT_INIT = 3'(SYS_DRAIN_CYCLES - 1);
  // The detection cycle is already the first stall cycle (combinational
  // Stall), so the registered STALL state only covers the remaining ones.
  localparam logic       BR_NEEDS_STATE = (BR_LOAD_STALLS > 1);
  localparam logic [2:0] BR_CNT_INIT    = BR_NEEDS_STATE ? 3'(BR_LOAD_STALLS - 2) : 3'd0;

  // ---------------- forwarding ----------------
  dest_t exe_d, mem_d, wb_d;
  assign exe_d = '{dst: EXE_WriteReg, wen: EXE_RegWrite};
  assign mem_d = '{dst: MEM_WriteReg, wen: MEM_RegWrite};
  assign wb_d  = '{dst: WB_WriteReg,  wen: WB_RegWrite};

  logic [NUM_OPS-1:0][4:0] src;
  logic [NUM_OPS-1:0]      uses;
  logic [NUM_OPS-1:0][1:0] sel;
  logic [NUM_OPS-1:0]      load_hit;

  assign src  = {ID_RegB, ID_RegA};
  assign uses = {ID_UsesB, ID_UsesA};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_select_unit u_fwd (
      .src          (src[g]),
      .uses         (uses[g]),
      .exe          (exe_d),
      .mem          (mem_d),
      .wb           (wb_d),
      .exe_load     (EXE_MemRead),
      .sel          (sel[g]),
      .exe_load_hit (load_hit[g])
    );
  end

  assign SelA = RESET ? sel[0] : FWD_SEL_REG;
  assign SelB = RESET ? sel[1] : FWD_SEL_REG;

  // ---------------- FSM ----------------
  hs_state_e  state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       any_load_hit, bl, detect;

  assign any_load_hit = |load_hit;
  assign bl           = any_load_hit && ID_BranchJR;
  // Syscall has priority: a hazard seen alongside it never stalls
  assign detect       = (state == HS_IDLE) && !ID_Syscall && any_load_hit;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= HS_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      HS_IDLE: begin
        if (ID_Syscall) begin
          state_n = HS_SYS_DRAIN;
          cnt_n   = SYS_CNT_INIT;
        end else if (bl && BR_NEEDS_STATE) begin
          state_n = HS_STALL;
          cnt_n   = BR_CNT_INIT;
        end
      end
      HS_STALL: begin
        if (cnt == 3'd0) state_n = HS_IDLE;
        else             cnt_n   = cnt - 3'd1;
      end
      HS_SYS_DRAIN: begin
        if (cnt == 3'd0) state_n = HS_SYS_ISSUE;
        else             cnt_n   = cnt - 3'd1;
      end
      HS_SYS_ISSUE:   state_n = HS_SYS_RECOVER;
      HS_SYS_RECOVER: state_n = HS_IDLE;
      default:        state_n = HS_IDLE;
    endcase
  end

  logic draining, inhibit;
  assign draining = (state == HS_SYS_DRAIN);
  assign inhibit  = (state == HS_SYS_ISSUE) || (state == HS_SYS_RECOVER);

  assign Stall       = RESET && ((state == HS_STALL) || detect);
  assign SYS         = RESET && (state == HS_SYS_ISSUE);
  assign WANT_FREEZE = RESET && (Stall || draining) && !inhibit;
  assign State_Dbg   = state;

endmodule

// File: tb/tb_id_hazard_scheduler.sv
module tb_id_hazard_scheduler;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] ID_RegA, ID_RegB, EXE_WriteReg, MEM_WriteReg, WB_WriteReg;
  logic       ID_UsesA, ID_UsesB, ID_BranchJR, ID_Syscall;
  logic       EXE_RegWrite, EXE_MemRead, MEM_RegWrite, WB_RegWrite;
  logic [1:0] SelA, SelB;
  logic       Stall, SYS, WANT_FREEZE;
  logic [2:0] State_Dbg;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  id_hazard_scheduler #(.SYS_DRAIN_CYCLES(3), .BR_LOAD_STALLS(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .ID_RegA(ID_RegA), .ID_RegB(ID_RegB), .ID_UsesA(ID_UsesA), .ID_UsesB(ID_UsesB),
    .ID_BranchJR(ID_BranchJR), .ID_Syscall(ID_Syscall),
    .EXE_WriteReg(EXE_WriteReg), .EXE_RegWrite(EXE_RegWrite), .EXE_MemRead(EXE_MemRead),
    .MEM_WriteReg(MEM_WriteReg), .MEM_RegWrite(MEM_RegWrite),
    .WB_WriteReg(WB_WriteReg), .WB_RegWrite(WB_RegWrite),
    .SelA(SelA), .SelB(SelB), .Stall(Stall), .SYS(SYS),
    .WANT_FREEZE(WANT_FREEZE), .State_Dbg(State_Dbg)
  );

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic clear_inputs();
    ID_RegA = 0; ID_RegB = 0; ID_UsesA = 0; ID_UsesB = 0;
    ID_BranchJR = 0; ID_Syscall = 0;
    EXE_WriteReg = 0; EXE_RegWrite = 0; EXE_MemRead = 0;
    MEM_WriteReg = 0; MEM_RegWrite = 0; WB_WriteReg = 0; WB_RegWrite = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET = 1'b0;
    tick(); tick();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    logic saw_sys;
    do_reset();
    tests++;
    if ({Stall, SYS, WANT_FREEZE, State_Dbg} !== 6'b0) begin
      fails++; $display("FAIL reset_outputs: got %b want 000000", {Stall, SYS, WANT_FREEZE, State_Dbg});
    end
    // forwarding selects are forced to regfile while reset is held
    RESET = 1'b0;
    ID_RegA = 5; ID_UsesA = 1; EXE_WriteReg = 5; EXE_RegWrite = 1;
    #1;
    tests++;
    if (SelA !== 2'd0) begin fails++; $display("FAIL reset_sela: got %0d want 0", SelA); end
    clear_inputs();
    RESET = 1'b1;
    tick();
    // start a syscall, reset in the middle of the drain
    ID_Syscall = 1; tick();
    ID_Syscall = 0; tick();
    tests++;
    if (State_Dbg !== 3'd2) begin fails++; $display("FAIL reset_pre_drain: got %0d want 2", State_Dbg); end
    RESET = 1'b0; tick(); tick();
    tests++;
    if ({Stall, SYS, WANT_FREEZE, State_Dbg} !== 6'b0) begin
      fails++; $display("FAIL reset_mid_drain: got %b want 000000", {Stall, SYS, WANT_FREEZE, State_Dbg});
    end
    RESET = 1'b1;
    saw_sys = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (SYS !== 1'b0) saw_sys = 1'b1;
      tick();
    end
    tests++;
    if (saw_sys !== 1'b0) begin fails++; $display("FAIL reset_no_sys: got %b want 0", saw_sys); end
  endtask

  task automatic test_forwarding();
    do_reset();
    EXE_WriteReg = 5; EXE_RegWrite = 1;
    MEM_WriteReg = 5; MEM_RegWrite = 1;
    WB_WriteReg  = 6; WB_RegWrite  = 1;
    ID_RegA = 5; ID_RegB = 6; ID_UsesA = 1; ID_UsesB = 1;
    #1;
    tests++;
    if (SelA !== 2'd1) begin fails++; $display("FAIL fwd_exe_a: got %0d want 1", SelA); end
    tests++;
    if (SelB !== 2'd3) begin fails++; $display("FAIL fwd_wb_b: got %0d want 3", SelB); end
    tests++;
    if (Stall !== 1'b0) begin fails++; $display("FAIL fwd_no_stall: got %b want 0", Stall); end
    ID_RegA = 0; #1;
    tests++;
    if (SelA !== 2'd0) begin fails++; $display("FAIL fwd_r0: got %0d want 0", SelA); end
    ID_RegA = 5; EXE_RegWrite = 0; #1;
    tests++;
    if (SelA !== 2'd2) begin fails++; $display("FAIL fwd_mem_a: got %0d want 2", SelA); end
    ID_UsesA = 0; #1;
    tests++;
    if (SelA !== 2'd0) begin fails++; $display("FAIL fwd_unused: got %0d want 0", SelA); end
    // rt follows the same priority: EXE beats WB
    EXE_WriteReg = 6; EXE_RegWrite = 1; #1;
    tests++;
    if (SelB !== 2'd1) begin fails++; $display("FAIL fwd_exe_b: got %0d want 1", SelB); end
  endtask

  task automatic test_load_use();
    do_reset();
    EXE_WriteReg = 8; EXE_RegWrite = 1; EXE_MemRead = 1;
    ID_RegA = 8; ID_UsesA = 1;
    #1;
    tests++;
    if (Stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b want 1", Stall); end
    tests++;
    if (SelA !== 2'd1) begin fails++; $display("FAIL lu_sel_exe: got %0d want 1", SelA); end
    tests++;
    if (WANT_FREEZE !== 1'b1) begin fails++; $display("FAIL lu_freeze: got %b want 1", WANT_FREEZE); end
    tick();
    // bubble now in EXE, load in MEM
    EXE_RegWrite = 0; EXE_MemRead = 0; EXE_WriteReg = 0;
    MEM_WriteReg = 8; MEM_RegWrite = 1;
    #1;
    tests++;
    if (Stall !== 1'b0) begin fails++; $display("FAIL lu_one_cycle: got %b want 0", Stall); end
    tests++;
    if (SelA !== 2'd2) begin fails++; $display("FAIL lu_sel_mem: got %0d want 2", SelA); end
    tests++;
    if (State_Dbg !== 3'd0) begin fails++; $display("FAIL lu_state: got %0d want 0", State_Dbg); end
  endtask

  task automatic test_branch_load();
    do_reset();
    EXE_WriteReg = 9; EXE_RegWrite = 1; EXE_MemRead = 1;
    ID_RegA = 9; ID_UsesA = 1; ID_BranchJR = 1;
    #1;
    tests++;
    if (Stall !== 1'b1) begin fails++; $display("FAIL bl_stall0: got %b want 1", Stall); end
    tick();
    EXE_RegWrite = 0; EXE_MemRead = 0; EXE_WriteReg = 0;
    MEM_WriteReg = 9; MEM_RegWrite = 1;
    #1;
    tests++;
    if (Stall !== 1'b1) begin fails++; $display("FAIL bl_stall1: got %b want 1", Stall); end
    tests++;
    if (State_Dbg !== 3'd1) begin fails++; $display("FAIL bl_state: got %0d want 1", State_Dbg); end
    tick();
    MEM_RegWrite = 0; MEM_WriteReg = 0;
    WB_WriteReg = 9; WB_RegWrite = 1;
    #1;
    tests++;
    if (Stall !== 1'b0) begin fails++; $display("FAIL bl_release: got %b want 0", Stall); end
    tests++;
    if (SelA !== 2'd3) begin fails++; $display("FAIL bl_sel_wb: got %0d want 3", SelA); end
    // a load already in MEM feeding a branch forwards without stalling
    do_reset();
    MEM_WriteReg = 9; MEM_RegWrite = 1;
    ID_RegB = 9; ID_UsesB = 1; ID_BranchJR = 1;
    #1;
    tests++;
    if ({Stall, SelB} !== 3'b0_10) begin fails++; $display("FAIL bl_mem_load: got %b want 010", {Stall, SelB}); end
  endtask

  task automatic test_syscall();
    // per cycle after detection: {WANT_FREEZE, SYS, State_Dbg}
    logic [4:0] exp_tbl [1:6];
    exp_tbl[1] = {1'b1, 1'b0, 3'd2};
    exp_tbl[2] = {1'b1, 1'b0, 3'd2};
    exp_tbl[3] = {1'b1, 1'b0, 3'd2};
    exp_tbl[4] = {1'b0, 1'b1, 3'd3};
    exp_tbl[5] = {1'b0, 1'b0, 3'd4};
    exp_tbl[6] = {1'b0, 1'b0, 3'd0};
    do_reset();
    ID_Syscall = 1; #1;
    tests++;
    if ({Stall, WANT_FREEZE, SYS} !== 3'b0) begin fails++; $display("FAIL sys_c0: got %b want 000", {Stall, WANT_FREEZE, SYS}); end
    tick();
    ID_Syscall = 0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      tests++;
      if ({WANT_FREEZE, SYS, State_Dbg} !== exp_tbl[k] || Stall !== 1'b0) begin
        fails++;
        $display("FAIL sys_c%0d: got frz=%b sys=%b st=%0d stall=%b want %b stall=0",
                 k, WANT_FREEZE, SYS, State_Dbg, Stall, exp_tbl[k]);
      end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_st [0:7];
    exp_st[0] = 3'd0; exp_st[1] = 3'd2; exp_st[2] = 3'd2; exp_st[3] = 3'd2;
    exp_st[4] = 3'd3; exp_st[5] = 3'd4; exp_st[6] = 3'd0; exp_st[7] = 3'd2;
    do_reset();
    // syscall held high together with a load-use hit the whole time
    ID_Syscall = 1;
    EXE_WriteReg = 8; EXE_RegWrite = 1; EXE_MemRead = 1;
    ID_RegA = 8; ID_UsesA = 1;
    for (int k = 0; k <= 7; k++) begin
      #1;
      tests++;
      if (State_Dbg !== exp_st[k] || Stall !== 1'b0) begin
        fails++;
        $display("FAIL simul_c%0d: got st=%0d stall=%b want st=%0d stall=0", k, State_Dbg, Stall, exp_st[k]);
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    RESET = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_load();
    test_syscall();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
